// File: rtl/flush_pkg.sv
// flush_pkg: shared constants and FSM state type for the screen flusher.
//   SCREEN_W / SCREEN_H : default raster size (160 x 120)
//   COLOUR_W            : colour width on decoder and VGA buses
//   COORD_W             : width of the flush scan counters
//   flush_state_t       : sequencer states IDLE, SCAN, DRAIN, DONE
package flush_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 6;
    localparam int COORD_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } flush_state_t;

endpackage

// File: rtl/screen_flusher_raster_counter.sv
// raster_counter: column/row scan counter for one frame sweep.
//   clk, resetn : clock, asynchronous active-low reset
//   clear       : force both counters to 0
//   advance     : step one pixel in raster order
//   x, y        : current column / row
//   last        : high while (x, y) is the final pixel (WIDTH-1, HEIGHT-1)
module raster_counter
    import flush_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               advance,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               last
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               w_x_end;
    logic               w_last;

    assign w_x_end = (r_x == X_LAST);
    assign w_last  = w_x_end && (r_y == Y_LAST);

    // Counter state: after the final pixel both counters park at 0,0 for the next frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x <= {COORD_W{1'b0}};
            r_y <= {COORD_W{1'b0}};
        end else if (clear) begin
            r_x <= {COORD_W{1'b0}};
            r_y <= {COORD_W{1'b0}};
        end else if (advance) begin
            if (w_last) begin
                r_x <= {COORD_W{1'b0}};
                r_y <= {COORD_W{1'b0}};
            end else if (w_x_end) begin
                r_x <= {COORD_W{1'b0}};
                r_y <= r_y + 8'd1;
            end else begin
                r_x <= r_x + 8'd1;
                r_y <= r_y;
            end
        end else begin
            r_x <= r_x;
            r_y <= r_y;
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign last = w_last;

endmodule

// File: rtl/screen_flusher.sv
// screen_flusher: sweeps the screen once per start request, presenting each
// pixel on the flush bus to combinational decoders and emitting one registered
// plot per pixel to the VGA adapter.
//   clk, resetn            : clock, asynchronous active-low reset
//   start                  : redraw request (only honoured in IDLE)
//   busy, done             : frame in progress / one-cycle completion pulse
//   flush_x, flush_y       : scan coordinate to the decoders
//   obj_enable, obj_colour : decoder hit and colour for the flush coordinate
//   vga_x, vga_y           : plot coordinate (vga_y is flush_y[6:0])
//   vga_colour, vga_plot   : plot colour and write strobe
// Build option: FLUSH_SKIP_BG_EN -- when defined, background pixels are swept
// but not written (vga_plot only for obj_enable=1); frame timing is unchanged.
module screen_flusher
    import flush_pkg::*;
#(
    parameter int                  WIDTH     = SCREEN_W,
    parameter int                  HEIGHT    = SCREEN_H,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = 6'b000000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [COORD_W-1:0]  flush_x,
    output logic [COORD_W-1:0]  flush_y,
    input  logic                obj_enable,
    input  logic [COLOUR_W-1:0] obj_colour,
    output logic [COORD_W-1:0]  vga_x,
    output logic [6:0]          vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    flush_state_t r_state;
    flush_state_t w_state_next;

    logic [COORD_W-1:0]  w_x;
    logic [COORD_W-1:0]  w_y;
    logic                w_last;
    logic                w_accept;
    logic                w_scan;
    logic                w_plot_next;

    logic                r_busy;
    logic                r_done;
    logic                r_vga_plot;
    logic [COORD_W-1:0]  r_vga_x;
    logic [6:0]          r_vga_y;
    logic [COLOUR_W-1:0] r_vga_colour;

    assign w_scan   = (r_state == SCAN);
    assign w_accept = (r_state == IDLE) && start;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster_counter (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (w_accept),
        .advance (w_scan),
        .x       (w_x),
        .y       (w_y),
        .last    (w_last)
    );

`ifdef FLUSH_SKIP_BG_EN
    assign w_plot_next = w_scan && obj_enable;
`else
    assign w_plot_next = w_scan;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; start outside IDLE is dropped, not queued.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SCAN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SCAN: begin
                if (w_last) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = SCAN;
                end
            end
            DRAIN:   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Registered outputs. These lag the state by one cycle, so the DRAIN
    // state yields the plot-low hold cycle and DONE yields the done pulse.
    // busy clears on the cycle after done unless a new start is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_vga_plot   <= 1'b0;
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= 6'd0;
        end else begin
            r_done     <= (r_state == DONE);
            r_vga_plot <= w_plot_next;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
            if (w_scan) begin
                r_vga_x      <= w_x;
                r_vga_y      <= w_y[6:0];
                r_vga_colour <= obj_enable ? obj_colour : BG_COLOUR;
            end else begin
                r_vga_x      <= r_vga_x;
                r_vga_y      <= r_vga_y;
                r_vga_colour <= r_vga_colour;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign flush_x    = w_x;
    assign flush_y    = w_y;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign vga_plot   = r_vga_plot;

endmodule
